// File: rtl/key_arb_pkg.sv
// Shared types and default sizing for the key arbiter.
package key_arb_pkg;

  localparam int N_DEF  = 4;
  localparam int KW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/key_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  logic [IW:0]  sum;

  // Rotate requests so bit k is requester (ptr+k) mod N; scan high to low so the lowest k wins.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    valid = |req;
    idx   = '0;
    sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) begin
          sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/key_arbiter.sv
// Round-robin arbiter sharing one req/key/ack consumer among N producers.
// All outputs come straight from flops, breaking any producer/consumer comb loop.
module key_arbiter
  import key_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int KW = KW_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    up_req,
  input  logic [N*KW-1:0] up_key,
  output logic [N-1:0]    up_ack,
  output logic            dn_req,
  output logic [KW-1:0]   dn_key,
  output logic [IW-1:0]   dn_src,
  input  logic            dn_ack,
  output logic            busy
);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [KW-1:0] pick_key;
  logic [N-1:0]  pick_onehot;

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req   (up_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the winner's key and build its one-hot ack pattern.
  always_comb begin
    pick_key    = '0;
    pick_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_key       = up_key[i*KW +: KW];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Pointer advances past the owner, wrapping explicitly for non-power-of-2 N.
  always_comb begin
    next_ptr = (dn_src == IW'(N - 1)) ? '0 : dn_src + IW'(1);
  end

  // FSM with registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      up_ack <= '0;
      dn_req <= 1'b0;
      dn_key <= '0;
      dn_src <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Key is sampled while up_ack is low, i.e. the pre-advance key.
          if (pick_valid) begin
            dn_key <= pick_key;
            dn_src <= pick_idx;
            up_ack <= pick_onehot;
            dn_req <= 1'b1;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          up_ack <= '0;
          rr_ptr <= next_ptr;
          if (dn_ack) begin
            dn_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (dn_ack) begin
            dn_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          up_ack <= '0;
          dn_req <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
